sync_fifo_param: RTL and testbench
==================================

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 Parameter DATA_WIDTH, default 8: data bus width in bits, legal range 1 to 64.
REQ-002 Parameter DEPTH, default 16: number of storage entries, a power of two, legal range 4 to 1024.
REQ-003 Parameter AF_LEVEL, default DEPTH-2: almost_full asserts when count >= AF_LEVEL.
REQ-004 Parameter AE_LEVEL, default 2: almost_empty asserts when count <= AE_LEVEL.
REQ-005 Parameter FWFT, default 0: 0 selects registered-read mode, 1 selects first-word-fall-through mode.
REQ-006 clk  input  1: rising-edge clock for all state.
REQ-007 rst_n  input  1: asynchronous, active-low reset.
REQ-008 clr  input  1: synchronous flush, active-high.
REQ-009 wr_n  input  1: write request, active-low.
REQ-010 rd_n  input  1: read request, active-low.
REQ-011 data_in  input  DATA_WIDTH: write data.
REQ-012 data_out  output  DATA_WIDTH: read data.
REQ-013 full, empty  output  1 each: occupancy flags.
REQ-014 almost_full, almost_empty  output  1 each: threshold flags.
REQ-015 count  output  log2(DEPTH)+1: current occupancy, range 0 to DEPTH.
REQ-016 over_flow, under_flow  output  1 each: single-cycle error pulses.

Function
REQ-017 Storage SHALL be a DEPTH x DATA_WIDTH array with read and write pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0 naturally.
REQ-018 full SHALL equal (count == DEPTH); empty SHALL equal (count == 0); almost_full and almost_empty SHALL be decoded from count in the same cycle, with no added latency.
REQ-019 A write SHALL be accepted when !wr_n and (!full or a read is accepted in the same cycle); an accepted write stores data_in at the write pointer and advances the pointer.
REQ-020 A read SHALL be accepted when !rd_n and !empty; an accepted read advances the read pointer.
REQ-021 A write to an empty FIFO with a simultaneous read SHALL accept the write and reject the read; the empty-FIFO bypass is not supported.
REQ-022 count SHALL change per cycle as follows: write only +1; read only -1; both accepted, unchanged; neither, unchanged.
REQ-023 count SHALL never exceed DEPTH or go below 0.
REQ-024 over_flow SHALL pulse high for exactly one cycle, the cycle after !wr_n is rejected because the FIFO is full.
REQ-025 under_flow SHALL pulse high for exactly one cycle, the cycle after !rd_n is rejected because the FIFO is empty.
REQ-026 A rejected access SHALL NOT alter the pointers, count, memory or data_out.
REQ-027 With FWFT=0, data_out SHALL update one cycle after an accepted read with the entry at the old read pointer, and hold its value otherwise.
REQ-028 With FWFT=1, data_out SHALL present the head entry whenever !empty, with the same-cycle read consuming it; data_out SHALL hold its last value while empty.
REQ-029 clr SHALL have priority over rd_n and wr_n: on the next edge, pointers and count go to 0 and both error pulses go to 0.
REQ-030 clr SHALL NOT change memory contents, and SHALL NOT change data_out in FWFT=0 mode.

Reset
REQ-031 While rst_n is low, the pointers, count, over_flow and under_flow SHALL be 0, empty and almost_empty SHALL be 1, and full and almost_full SHALL be 0.
REQ-032 Reset SHALL set data_out to 0 and SHALL NOT clear the memory array.
REQ-033 Reset asserted mid-operation SHALL take effect immediately without waiting for clk; the first accepted access after deassertion SHALL use pointer 0.

Verification
REQ-034 Defaults, reset then 16 consecutive writes of 0x00..0x0F -> count=16, full=1, almost_full=1 from count=14; a 17th write gives over_flow=1 for one cycle and count stays 16.
REQ-035 From full, 16 reads with FWFT=0 -> data_out 0x00..0x0F in order, each one cycle after its read; then empty=1 and count=0; a further read gives under_flow=1 for one cycle.
REQ-036 Wrap-around: write 10, read 10, write 12, read 12 -> data integrity holds across the pointer wrap, and count tracks 0..12..0.
REQ-037 Simultaneous read and write at full -> both accepted, count=16, over_flow=0; at empty -> write accepted, read rejected, count=1, under_flow=1.
REQ-038 Mid-operation events: clr at count=7 -> count=0 and empty=1 next cycle; rst_n pulsed low between clock edges at count=5 -> count=0 immediately.
REQ-039 FWFT=1 with DEPTH=4 and DATA_WIDTH=32: write 0xDEADBEEF -> data_out=0xDEADBEEF the cycle after the write, before any read is issued.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Parameterised synchronous FIFO with occupancy/threshold flags, error pulses and
// selectable registered-read or first-word-fall-through output.
module sync_fifo_param #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AF_LEVEL   = DEPTH - 2,
  parameter int unsigned AE_LEVEL   = 2,
  parameter int unsigned FWFT       = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       wr_n,
  input  logic                       rd_n,
  input  logic [DATA_WIDTH-1:0]      data_in,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       over_flow,
  output logic                       under_flow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  over_flow_q, over_flow_d;
  logic                  under_flow_q, under_flow_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] head;
  logic                  wr_acc, rd_acc;

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    full         = (count_q == CW'(DEPTH));
    empty        = (count_q == '0);
    almost_full  = (count_q >= CW'(AF_LEVEL));
    almost_empty = (count_q <= CW'(AE_LEVEL));
    count        = count_q;
    over_flow    = over_flow_q;
    under_flow   = under_flow_q;
    // In FWFT mode the head entry is shown live; data_q keeps the last shown word for empty.
    data_out     = ((FWFT != 0) && !empty) ? head : data_q;
  end

  // A read never bypasses into an empty FIFO; a write at full rides on a same-cycle read.
  assign rd_acc = !rd_n && !empty;
  assign wr_acc = !wr_n && (!full || rd_acc);

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    over_flow_d  = 1'b0;
    under_flow_d = 1'b0;
    data_d       = data_q;
    if (FWFT != 0) begin
      if (!empty) data_d = head;
    end else if (rd_acc && !clr) begin
      data_d = head;
    end
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      over_flow_d  = !wr_n && !wr_acc;
      under_flow_d = !rd_n && !rd_acc;
      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      over_flow_q  <= 1'b0;
      under_flow_q <= 1'b0;
      data_q       <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      over_flow_q  <= over_flow_d;
      under_flow_q <= under_flow_d;
      data_q       <= data_d;
    end
  end

  // Storage is deliberately left out of reset and flush.
  always_ff @(posedge clk) begin
    if (wr_acc && !clr) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: directed scenarios plus random traffic
// against a queue-based reference model; a second FWFT instance covers fall-through.
module tb_sync_fifo_param;

  localparam int unsigned Depth = 16;
  localparam int unsigned AfLvl = Depth - 2;
  localparam int unsigned AeLvl = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       wr_n = 1'b1;
  logic       rd_n = 1'b1;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       full, empty, almost_full, almost_empty, over_flow, under_flow;
  logic [4:0] count;

  logic        f_clr = 1'b0;
  logic        f_wr_n = 1'b1;
  logic        f_rd_n = 1'b1;
  logic [31:0] f_din = '0;
  logic [31:0] f_dout;
  logic        f_full, f_empty, f_af, f_ae, f_ov, f_un;
  logic [2:0]  f_count;

  int total = 0;
  int bad = 0;

  logic [7:0] q[$];
  logic [7:0] exp_dout = '0;
  logic       exp_ov = 1'b0;
  logic       exp_un = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_param u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .wr_n         (wr_n),
    .rd_n         (rd_n),
    .data_in      (data_in),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .over_flow    (over_flow),
    .under_flow   (under_flow)
  );

  sync_fifo_param #(
    .DATA_WIDTH (32),
    .DEPTH      (4),
    .FWFT       (1)
  ) u_fwft (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (f_clr),
    .wr_n         (f_wr_n),
    .rd_n         (f_rd_n),
    .data_in      (f_din),
    .data_out     (f_dout),
    .full         (f_full),
    .empty        (f_empty),
    .almost_full  (f_af),
    .almost_empty (f_ae),
    .count        (f_count),
    .over_flow    (f_ov),
    .under_flow   (f_un)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ".count"},  64'(count),        64'(n));
    chk({tag, ".full"},   64'(full),         64'(n == Depth));
    chk({tag, ".empty"},  64'(empty),        64'(n == 0));
    chk({tag, ".afull"},  64'(almost_full),  64'(n >= AfLvl));
    chk({tag, ".aempty"}, 64'(almost_empty), 64'(n <= AeLvl));
    chk({tag, ".ovf"},    64'(over_flow),    64'(exp_ov));
    chk({tag, ".unf"},    64'(under_flow),   64'(exp_un));
    chk({tag, ".dout"},   64'(data_out),     64'(exp_dout));
  endtask

  // Drive at a falling edge, let one rising edge pass, update the model, check at the next fall.
  task automatic step(input bit wr, input bit rd, input logic [7:0] din, input bit c,
                      input string tag);
    bit ra, wa;
    wr_n = !wr;
    rd_n = !rd;
    data_in = din;
    clr = c;
    @(posedge clk);
    if (c) begin
      q.delete();
      exp_ov = 1'b0;
      exp_un = 1'b0;
    end else begin
      ra = rd && (q.size() > 0);
      wa = wr && ((q.size() < Depth) || ra);
      exp_ov = wr && !wa;
      exp_un = rd && !ra;
      if (ra) exp_dout = q.pop_front();
      if (wa) q.push_back(din);
    end
    @(negedge clk);
    wr_n = 1'b1;
    rd_n = 1'b1;
    clr = 1'b0;
    check_all(tag);
  endtask

  initial begin
    logic [7:0] d;
    // Reset held from time zero
    repeat (2) @(negedge clk);
    check_all("reset");
    chk("reset.f_dout",  64'(f_dout), 64'h0);
    chk("reset.f_empty", 64'(f_empty), 64'h1);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill with 0x00..0x0F, then one overflowing write
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i), 1'b0, "fill");
    step(1'b1, 1'b0, 8'hAA, 1'b0, "ovf_write");
    step(1'b0, 1'b0, 8'h00, 1'b0, "ovf_idle");

    // Drain in order, then one underflowing read
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00, 1'b0, "drain");
    step(1'b0, 1'b1, 8'h00, 1'b0, "unf_read");
    step(1'b0, 1'b0, 8'h00, 1'b0, "unf_idle");

    // Pointer wrap
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0, "wrap_w10");
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h00, 1'b0, "wrap_r10");
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0, "wrap_w12");
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 8'h00, 1'b0, "wrap_r12");

    // Simultaneous read/write at full and at empty
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0, "refill");
    step(1'b1, 1'b1, 8'h5A, 1'b0, "rw_full");
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00, 1'b0, "redrain");
    step(1'b1, 1'b1, 8'hC3, 1'b0, "rw_empty");
    step(1'b0, 1'b1, 8'h00, 1'b0, "rw_empty_rd");

    // Flush at count 7
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0, "pre_clr");
    step(1'b1, 1'b1, 8'h77, 1'b1, "clr");
    step(1'b0, 1'b1, 8'h00, 1'b0, "post_clr_rd");

    // Asynchronous reset between edges at count 5
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0, "pre_rst");
    #2 rst_n = 1'b0;
    q.delete();
    exp_dout = '0;
    exp_ov = 1'b0;
    exp_un = 1'b0;
    #1 check_all("async_rst");
    #1 rst_n = 1'b1;
    @(negedge clk);
    d = 8'($urandom);
    step(1'b1, 1'b0, d, 1'b0, "post_rst_w");
    step(1'b0, 1'b1, 8'h00, 1'b0, "post_rst_r");

    // Random traffic in phases biased toward filling, draining and balance
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 150; i++) begin
        int wp;
        wp = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
        step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < (100 - wp),
             8'($urandom), $urandom_range(0, 79) == 0, "rand");
      end
    end

    // Fall-through instance
    f_wr_n = 1'b0;
    f_din = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    f_wr_n = 1'b1;
    chk("fwft_w1.dout",  64'(f_dout), 64'hDEADBEEF);
    chk("fwft_w1.count", 64'(f_count), 64'h1);
    chk("fwft_w1.empty", 64'(f_empty), 64'h0);
    f_wr_n = 1'b0;
    f_din = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    f_wr_n = 1'b1;
    chk("fwft_w2.dout",  64'(f_dout), 64'hDEADBEEF);
    chk("fwft_w2.count", 64'(f_count), 64'h2);
    f_rd_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("fwft_r1.dout",  64'(f_dout), 64'h12345678);
    chk("fwft_r1.count", 64'(f_count), 64'h1);
    @(posedge clk);
    @(negedge clk);
    f_rd_n = 1'b1;
    chk("fwft_r2.empty", 64'(f_empty), 64'h1);
    chk("fwft_r2.dout",  64'(f_dout), 64'h12345678);
    @(negedge clk);
    chk("fwft_idle.unf", 64'(f_un), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
